// File: rtl/weight_mem_loader.sv
// Bring-up loader: assembles a little-endian byte stream into weight words and
// writes them to consecutive weight memory addresses, then reports done.
module weight_mem_loader #(
   parameter int num_weight    = 3,
   parameter int address_width = 2,
   parameter int data_width    = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     in_valid,
   input  logic [7:0]               in_data,
   output logic                     in_ready,
   output logic                     w_en,
   output logic [address_width-1:0] w_add,
   output logic [data_width-1:0]    w_in,
   output logic                     busy,
   output logic                     done,
   output logic [address_width:0]   words_written
);

   localparam int BYTES = data_width / 8;
   localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;

   // state | meaning
   // IDLE  | waiting for start after reset
   // LOAD  | accepting bytes of the current word
   // WRITE | one-cycle write strobe of the assembled word
   // DONE  | all words written, waiting for a new start
   typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

   state_t                   state_q, state_d;
   logic [BCW-1:0]           byte_cnt_q, byte_cnt_d;
   logic [address_width-1:0] word_cnt_q, word_cnt_d;
   logic [data_width-1:0]    asm_q, asm_d;
   logic                     w_en_q, w_en_d;
   logic [address_width-1:0] w_add_q, w_add_d;
   logic [data_width-1:0]    w_in_q, w_in_d;
   logic                     busy_q, busy_d;
   logic                     done_q, done_d;
   logic [address_width:0]   words_written_q, words_written_d;

   assign in_ready      = (state_q == LOAD);
   assign w_en          = w_en_q;
   assign w_add         = w_add_q;
   assign w_in          = w_in_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign words_written = words_written_q;

   always_comb begin
      state_d         = state_q;
      byte_cnt_d      = byte_cnt_q;
      word_cnt_d      = word_cnt_q;
      asm_d           = asm_q;
      w_en_d          = 1'b0;
      w_add_d         = w_add_q;
      w_in_d          = w_in_q;
      words_written_d = words_written_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d         = LOAD;
               byte_cnt_d      = '0;
               word_cnt_d      = '0;
               words_written_d = '0;
            end
         end
         LOAD: begin
            if (in_valid && in_ready) begin
               for (int b = 0; b < BYTES; b++) begin
                  if (byte_cnt_q == BCW'(b)) asm_d[8*b +: 8] = in_data;
               end
               // Strobe is registered, so it lands the cycle after the last byte.
               if (byte_cnt_q == BCW'(BYTES-1)) begin
                  state_d         = WRITE;
                  byte_cnt_d      = '0;
                  w_en_d          = 1'b1;
                  w_add_d         = word_cnt_q;
                  w_in_d          = asm_d;
                  words_written_d = words_written_q + 1'b1;
               end else begin
                  byte_cnt_d = byte_cnt_q + 1'b1;
               end
            end
         end
         WRITE: begin
            if (word_cnt_q == address_width'(num_weight-1)) begin
               state_d = DONE;
            end else begin
               word_cnt_d = word_cnt_q + 1'b1;
               state_d    = LOAD;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == LOAD) || (state_d == WRITE);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= IDLE;
         byte_cnt_q      <= '0;
         word_cnt_q      <= '0;
         asm_q           <= '0;
         w_en_q          <= 1'b0;
         w_add_q         <= '0;
         w_in_q          <= '0;
         busy_q          <= 1'b0;
         done_q          <= 1'b0;
         words_written_q <= '0;
      end else begin
         state_q         <= state_d;
         byte_cnt_q      <= byte_cnt_d;
         word_cnt_q      <= word_cnt_d;
         asm_q           <= asm_d;
         w_en_q          <= w_en_d;
         w_add_q         <= w_add_d;
         w_in_q          <= w_in_d;
         busy_q          <= busy_d;
         done_q          <= done_d;
         words_written_q <= words_written_d;
      end
   end

endmodule

// File: tb/tb_weight_mem_loader.sv
// Bench for weight_mem_loader: directed table, corner sequences and random
// stimulus checked against a transaction-level model of the loader.
module tb_weight_mem_loader;

   localparam int NW    = 3;
   localparam int AW    = 2;
   localparam int DW    = 16;
   localparam int BYTES = DW / 8;

   logic          clk = 1'b0;
   logic          rst, start, in_valid;
   logic [7:0]    in_data;
   logic          in_ready, w_en, busy, done;
   logic [AW-1:0] w_add;
   logic [DW-1:0] w_in;
   logic [AW:0]   words_written;

   weight_mem_loader #(.num_weight(NW), .address_width(AW), .data_width(DW)) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .w_en(w_en), .w_add(w_add), .w_in(w_in),
      .busy(busy), .done(done), .words_written(words_written)
   );

   always #5 clk = ~clk;

   // stand-in for weight_mem, written by the loader's strobe
   logic [DW-1:0] tb_mem [2**AW];
   int            wen_count = 0;
   always @(posedge clk) begin
      if (w_en === 1'b1) begin
         tb_mem[w_add] <= w_in;
         wen_count     <= wen_count + 1;
      end
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // reference model: a run, a pending write cycle, and a queue of bytes of the open word
   bit          m_run, m_wr, m_done;
   logic [7:0]  m_q [$];
   int          m_words;
   bit          e_rdy, e_wen;
   int          e_wadd, e_win;
   logic [DW-1:0] m_mem [2**AW];

   function automatic void model_step(bit r, bit s, bit v, logic [7:0] d);
      bit          was_rdy;
      logic [31:0] word;
      if (r) begin
         m_run = 0; m_wr = 0; m_done = 0; m_q.delete(); m_words = 0;
         e_wen = 0; e_wadd = 0; e_win = 0;
      end else begin
         was_rdy = m_run && !m_wr;
         e_wen   = 0;
         if (m_wr) begin
            m_wr = 0;
            if (m_words == NW) begin m_run = 0; m_done = 1; end
         end else if (was_rdy) begin
            if (v) begin
               m_q.push_back(d);
               if (m_q.size() == BYTES) begin
                  word = 0;
                  for (int i = 0; i < BYTES; i++) word |= 32'(m_q[i]) << (8*i);
                  e_wadd = m_words;
                  e_win  = word;
                  m_mem[m_words] = word[DW-1:0];
                  m_words++;
                  e_wen = 1;
                  m_wr  = 1;
                  m_q.delete();
               end
            end
         end else if (s) begin
            m_run = 1; m_done = 0; m_words = 0; m_q.delete();
         end
      end
      e_rdy = m_run && !m_wr;
   endfunction

   task automatic compare_model();
      chk("in_ready", in_ready, e_rdy);
      chk("w_en", w_en, e_wen);
      chk("busy", busy, m_run);
      chk("done", done, m_done);
      chk("words_written", words_written, m_words);
      chk("w_add", w_add, e_wadd);
      chk("w_in", w_in, e_win);
   endtask

   task automatic cycle(input bit r, input bit s, input bit v, input logic [7:0] d);
      rst = r; start = s; in_valid = v; in_data = d;
      @(posedge clk);
      model_step(r, s, v, d);
      #1;
      compare_model();
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      bit hs;
      int tries;
      repeat (gap) cycle(0, 0, 0, 8'h00);
      tries = 0;
      do begin
         hs = e_rdy;
         cycle(0, 0, 1, b);
         tries++;
      end while (!hs && tries < 20);
      if (!hs) chk("handshake_timeout", 0, 1);
   endtask

   typedef struct {
      logic       rst, start, vld;
      logic [7:0] dat;
      logic       rdy, wen, bsy, dn;
      logic [2:0] ww;
      logic [1:0] wadd;
      logic [15:0] win;
   } vec_t;

   function automatic vec_t mk(logic r, logic s, logic v, logic [7:0] d, logic rdy, logic wen,
                               logic bsy, logic dn, logic [2:0] ww, logic [1:0] wa, logic [15:0] wi);
      vec_t t;
      t.rst = r; t.start = s; t.vld = v; t.dat = d; t.rdy = rdy; t.wen = wen;
      t.bsy = bsy; t.dn = dn; t.ww = ww; t.wadd = wa; t.win = wi;
      return t;
   endfunction

   vec_t tbl [14];

   initial begin
      int wc;
      rst = 1; start = 1; in_valid = 1; in_data = 8'h55;
      //            rst st  vld data   rdy wen bsy dn ww  wadd win
      tbl[0]  = mk(1, 1, 1, 8'h55,  0, 0, 0, 0, 0, 0, 16'h0000);
      tbl[1]  = mk(1, 1, 1, 8'h55,  0, 0, 0, 0, 0, 0, 16'h0000);
      tbl[2]  = mk(0, 1, 0, 8'h00,  1, 0, 1, 0, 0, 0, 16'h0000);
      tbl[3]  = mk(0, 0, 1, 8'h34,  1, 0, 1, 0, 0, 0, 16'h0000);
      tbl[4]  = mk(0, 0, 1, 8'h12,  0, 1, 1, 0, 1, 0, 16'h1234);
      tbl[5]  = mk(0, 0, 1, 8'h78,  1, 0, 1, 0, 1, 0, 16'h1234);
      tbl[6]  = mk(0, 0, 1, 8'h78,  1, 0, 1, 0, 1, 0, 16'h1234);
      tbl[7]  = mk(0, 0, 1, 8'h56,  0, 1, 1, 0, 2, 1, 16'h5678);
      tbl[8]  = mk(0, 0, 1, 8'hBC,  1, 0, 1, 0, 2, 1, 16'h5678);
      tbl[9]  = mk(0, 0, 1, 8'hBC,  1, 0, 1, 0, 2, 1, 16'h5678);
      tbl[10] = mk(0, 0, 1, 8'h9A,  0, 1, 1, 0, 3, 2, 16'h9ABC);
      tbl[11] = mk(0, 0, 0, 8'h00,  0, 0, 0, 1, 3, 2, 16'h9ABC);
      tbl[12] = mk(0, 0, 1, 8'hFF,  0, 0, 0, 1, 3, 2, 16'h9ABC);
      tbl[13] = mk(0, 0, 1, 8'hFF,  0, 0, 0, 1, 3, 2, 16'h9ABC);

      for (int i = 0; i < 14; i++) begin
         rst = tbl[i].rst; start = tbl[i].start; in_valid = tbl[i].vld; in_data = tbl[i].dat;
         @(posedge clk);
         model_step(tbl[i].rst, tbl[i].start, tbl[i].vld, tbl[i].dat);
         #1;
         chk($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].rdy);
         chk($sformatf("tbl%0d_w_en", i), w_en, tbl[i].wen);
         chk($sformatf("tbl%0d_busy", i), busy, tbl[i].bsy);
         chk($sformatf("tbl%0d_done", i), done, tbl[i].dn);
         chk($sformatf("tbl%0d_words_written", i), words_written, tbl[i].ww);
         chk($sformatf("tbl%0d_w_add", i), w_add, tbl[i].wadd);
         chk($sformatf("tbl%0d_w_in", i), w_in, tbl[i].win);
      end
      chk("mem0_b2b", tb_mem[0], 16'h1234);
      chk("mem1_b2b", tb_mem[1], 16'h5678);
      chk("mem2_b2b", tb_mem[2], 16'h9ABC);

      // stalled stream, start pulsed mid-run after the first byte
      wc = wen_count;
      cycle(0, 1, 0, 8'h00);
      send_byte(8'h34, 3);
      cycle(0, 1, 0, 8'h00);
      send_byte(8'h12, 3);
      send_byte(8'h78, 3);
      send_byte(8'h56, 3);
      send_byte(8'hBC, 3);
      send_byte(8'h9A, 3);
      chk("stall_last_wen", w_en, 1);
      chk("stall_last_win", w_in, 16'h9ABC);
      cycle(0, 0, 0, 8'h00);
      chk("stall_done", done, 1);
      chk("stall_wen_count", wen_count - wc, 3);
      chk("mem0_stall", tb_mem[0], 16'h1234);
      chk("mem2_stall", tb_mem[2], 16'h9ABC);

      // byte offered in DONE is not taken
      wc = wen_count;
      repeat (3) cycle(0, 0, 1, 8'hFF);
      chk("done_reject_ww", words_written, 3);
      chk("done_reject_wen", wen_count - wc, 0);

      // restart from DONE
      cycle(0, 1, 0, 8'h00);
      chk("restart_done_clr", done, 0);
      send_byte(8'hEF, 0);
      send_byte(8'hBE, 0);
      chk("restart_wen", w_en, 1);
      chk("restart_wadd", w_add, 0);
      chk("restart_win", w_in, 16'hBEEF);

      // finish that run, then reset mid-word of a new run
      send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0); send_byte(8'h04, 0);
      cycle(0, 0, 0, 8'h00);
      cycle(0, 1, 0, 8'h00);
      send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0);
      wc = wen_count;
      cycle(1, 0, 1, 8'hAA);
      chk("midrst_in_ready", in_ready, 0);
      chk("midrst_busy", busy, 0);
      repeat (4) cycle(0, 0, 1, 8'hAA);
      chk("idle_reject_wen", wen_count - wc, 0);
      chk("idle_reject_ww", words_written, 0);
      chk("midrst_mem1", tb_mem[1], 16'h0201);

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         cycle($urandom_range(0, 249) == 0, $urandom_range(0, 7) == 0,
               $urandom_range(0, 3) != 0, 8'($urandom));
      end
      for (int i = 0; i < NW; i++) begin
         if (m_words > i) chk($sformatf("rand_mem%0d", i), tb_mem[i], m_mem[i]);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
